// File: rtl/cla_pkg.sv
// Shared constants, types and helpers for the registered carry-lookahead adder.
package cla_pkg;

  localparam int CLA_GRP = 4;

  typedef struct packed {
    logic g;
    logic p;
  } cla_gp_t;

  function automatic int cla_num_groups(input int bit_w);
    return bit_w / CLA_GRP;
  endfunction

endpackage

// File: rtl/cla_group4.sv
// 4-bit lookahead group: sum bits from a flattened carry expansion, plus group generate/propagate.
// Purely combinational; no state and no flow control.
module cla_group4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] s,
  output logic       grp_g,
  output logic       grp_p
);

  logic [3:0] g;
  logic [3:0] p;
  logic [3:0] c;

  always_comb begin
    g = a & b;
    p = a ^ b;

    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);

    s = p ^ c;

    grp_g = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0]);
    grp_p = &p;
  end

endmodule

// File: rtl/cla_adder_reg.sv
// BIT-wide two-level carry-lookahead adder with registered sum/carry; 1-cycle latency, one add per cycle, no backpressure.
// Optional macro CLA_SELFCHECK_EN adds a registered o_mismatch against a behavioural reference.
module cla_adder_reg
  import cla_pkg::*;
#(
  parameter int BIT = 32,
  parameter int GRP = CLA_GRP
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_valid,
  input  logic [BIT-1:0] i_data_a,
  input  logic [BIT-1:0] i_data_b,
  input  logic           i_carry,
  output logic           o_valid,
  output logic [BIT-1:0] o_data_s,
  output logic           o_carry
`ifdef CLA_SELFCHECK_EN
  ,
  output logic           o_mismatch
`endif
);

  localparam int NG   = cla_num_groups(BIT);
  localparam int NBLK = (NG + 3) / 4;
  localparam int NPAD = NBLK * 4;

  cla_gp_t [NG-1:0]   gp;
  logic    [NPAD-1:0] g_pad;
  logic    [NPAD-1:0] p_pad;
  logic    [NPAD-1:0] cin_pad;
  logic    [BIT-1:0]  sum_w;
  logic               cout_w;

  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    cla_group4 u_grp (
      .a     (i_data_a[gi*GRP +: GRP]),
      .b     (i_data_b[gi*GRP +: GRP]),
      .cin   (cin_pad[gi]),
      .s     (sum_w[gi*GRP +: GRP]),
      .grp_g (gp[gi].g),
      .grp_p (gp[gi].p)
    );
  end

  // Padding groups beyond NG are never referenced by a live carry term.
  always_comb begin
    g_pad = '0;
    p_pad = '0;
    for (int i = 0; i < NG; i++) begin
      g_pad[i] = gp[i].g;
      p_pad[i] = gp[i].p;
    end
  end

  // Second-level lookahead: each group carry is a flat sum of products over its block;
  // only the block carry chains from one block of 4 groups to the next.
  always_comb begin : lookahead
    logic cblk;
    logic cnxt;
    logic acc;
    logic t;
    int   base;
    int   n;
    cin_pad = '0;
    cblk    = i_carry;
    cnxt    = 1'b0;
    acc     = 1'b0;
    t       = 1'b0;
    for (int blk = 0; blk < NBLK; blk++) begin
      base = blk * 4;
      n    = (NG - base < 4) ? (NG - base) : 4;
      cnxt = 1'b0;
      for (int j = 0; j <= 4; j++) begin
        acc = cblk;
        for (int k = 0; k < 4; k++)
          if (k < j) acc = acc & p_pad[base+k];
        for (int k = 0; k < 4; k++) begin
          if (k < j) begin
            t = g_pad[base+k];
            for (int m = 0; m < 4; m++)
              if (m > k && m < j) t = t & p_pad[base+m];
            acc = acc | t;
          end
        end
        if (j < 4) cin_pad[base+j] = acc;
        if (j == n) cnxt = acc;
      end
      cblk = cnxt;
    end
    cout_w = cblk;
  end

  logic           valid_d, valid_q;
  logic [BIT-1:0] sum_d,   sum_q;
  logic           carry_d, carry_q;

  always_comb begin
    valid_d = i_valid;
    sum_d   = sum_q;
    carry_d = carry_q;
    if (i_valid) begin
      sum_d   = sum_w;
      carry_d = cout_w;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      carry_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
    end
  end

  assign o_valid  = valid_q;
  assign o_data_s = sum_q;
  assign o_carry  = carry_q;

`ifdef CLA_SELFCHECK_EN
  logic [BIT:0] ref_d,      ref_q;
  logic         mismatch_d, mismatch_q;

  always_comb begin
    ref_d      = {1'b0, i_data_a} + {1'b0, i_data_b} + {{BIT{1'b0}}, i_carry};
    mismatch_d = i_valid && ({cout_w, sum_w} != ref_d);
    if (!i_valid) ref_d = ref_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      ref_q      <= '0;
      mismatch_q <= 1'b0;
    end else begin
      ref_q      <= ref_d;
      mismatch_q <= mismatch_d;
    end
  end

  assign o_mismatch = mismatch_q;

`ifndef SYNTHESIS
  always_ff @(posedge i_clk) begin
    if (mismatch_q)
      $error("cla_adder_reg: lookahead result %h differs from reference %h", {carry_q, sum_q}, ref_q);
  end
`endif
`endif

endmodule

// File: tb/tb_cla_adder_reg.sv
// Bench for cla_adder_reg: directed vector table, streaming/hold sequence, random run vs a "+" model, BIT=8/16 sweep.
module tb_cla_adder_reg;

  logic        clk = 1'b0;
  logic        i_rst;
  logic        i_valid;
  logic [31:0] i_data_a, i_data_b;
  logic        i_carry;
  logic        o_valid;
  logic [31:0] o_data_s;
  logic        o_carry;

  logic        v8, v16, ci8, ci16;
  logic [7:0]  a8, b8;
  logic [15:0] a16, b16;
  logic        ov8, ov16, co8, co16;
  logic [7:0]  s8;
  logic [15:0] s16;

`ifdef CLA_SELFCHECK_EN
  logic mm32, mm8, mm16;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cla_adder_reg #(.BIT(32)) dut32 (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_data_a(i_data_a), .i_data_b(i_data_b),
    .i_carry(i_carry), .o_valid(o_valid), .o_data_s(o_data_s), .o_carry(o_carry)
`ifdef CLA_SELFCHECK_EN
    , .o_mismatch(mm32)
`endif
  );

  cla_adder_reg #(.BIT(8)) dut8 (
    .i_clk(clk), .i_rst(i_rst), .i_valid(v8), .i_data_a(a8), .i_data_b(b8),
    .i_carry(ci8), .o_valid(ov8), .o_data_s(s8), .o_carry(co8)
`ifdef CLA_SELFCHECK_EN
    , .o_mismatch(mm8)
`endif
  );

  cla_adder_reg #(.BIT(16)) dut16 (
    .i_clk(clk), .i_rst(i_rst), .i_valid(v16), .i_data_a(a16), .i_data_b(b16),
    .i_carry(ci16), .o_valid(ov16), .o_data_s(s16), .o_carry(co16)
`ifdef CLA_SELFCHECK_EN
    , .o_mismatch(mm16)
`endif
  );

  typedef struct {
    string       name;
    logic        rst;
    logic        vld;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        exp_v;
    logic [31:0] exp_s;
    logic        exp_c;
  } vec_t;

  vec_t tbl[$];

  // Expected state of the 32-bit adder outputs, advanced one edge at a time.
  logic        m_v;
  logic [31:0] m_s;
  logic        m_c;
  logic        m8_v, m8_c, m16_v, m16_c;
  logic [7:0]  m8_s;
  logic [15:0] m16_s;

  task automatic step(input logic rst, input logic vld, input logic [31:0] a,
                      input logic [31:0] b, input logic cin);
    i_rst    = rst;
    i_valid  = vld;
    i_data_a = a;
    i_data_b = b;
    i_carry  = cin;
    @(posedge clk);
    #1;
  endtask

  task automatic model32(input logic rst, input logic vld, input logic [31:0] a,
                         input logic [31:0] b, input logic cin);
    logic [32:0] full;
    full = 33'(a) + 33'(b) + 33'(cin);
    if (rst) begin
      m_v = 1'b0; m_s = '0; m_c = 1'b0;
    end else if (vld) begin
      m_v = 1'b1; m_s = full[31:0]; m_c = full[32];
    end else begin
      m_v = 1'b0;
    end
  endtask

  task automatic check32(input string name, input logic ev, input logic [31:0] es, input logic ec);
    total++;
    if ({o_valid, o_carry, o_data_s} !== {ev, ec, es}) begin
      bad++;
      $display("FAIL %s: got v=%0b c=%0b s=%h, want v=%0b c=%0b s=%h",
               name, o_valid, o_carry, o_data_s, ev, ec, es);
    end
`ifdef CLA_SELFCHECK_EN
    total++;
    if (mm32 !== 1'b0) begin
      bad++;
      $display("FAIL %s mismatch32: got %0b want 0", name, mm32);
    end
`endif
  endtask

  task automatic step_w(input logic rst, input logic vld8, input logic [7:0] x8, input logic [7:0] y8,
                        input logic c8, input logic vld16, input logic [15:0] x16,
                        input logic [15:0] y16, input logic c16);
    logic [8:0]  f8;
    logic [16:0] f16;
    i_rst = rst; i_valid = 1'b0;
    v8 = vld8; a8 = x8; b8 = y8; ci8 = c8;
    v16 = vld16; a16 = x16; b16 = y16; ci16 = c16;
    @(posedge clk);
    #1;
    f8  = 9'(x8) + 9'(y8) + 9'(c8);
    f16 = 17'(x16) + 17'(y16) + 17'(c16);
    if (rst) begin
      m8_v = 0; m8_s = '0; m8_c = 0; m16_v = 0; m16_s = '0; m16_c = 0;
    end else begin
      m8_v = vld8;
      if (vld8) {m8_c, m8_s} = f8;
      m16_v = vld16;
      if (vld16) {m16_c, m16_s} = f16;
    end
  endtask

  task automatic check_w(input string name);
    total++;
    if ({ov8, co8, s8} !== {m8_v, m8_c, m8_s}) begin
      bad++;
      $display("FAIL %s bit8: got v=%0b c=%0b s=%h, want v=%0b c=%0b s=%h",
               name, ov8, co8, s8, m8_v, m8_c, m8_s);
    end
    total++;
    if ({ov16, co16, s16} !== {m16_v, m16_c, m16_s}) begin
      bad++;
      $display("FAIL %s bit16: got v=%0b c=%0b s=%h, want v=%0b c=%0b s=%h",
               name, ov16, co16, s16, m16_v, m16_c, m16_s);
    end
`ifdef CLA_SELFCHECK_EN
    total++;
    if ({mm8, mm16} !== 2'b00) begin
      bad++;
      $display("FAIL %s mismatch8/16: got %0b%0b want 00", name, mm8, mm16);
    end
`endif
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic        rc, rv, rr;

    v8 = 0; a8 = '0; b8 = '0; ci8 = 0;
    v16 = 0; a16 = '0; b16 = '0; ci16 = 0;
    i_rst = 1'b1; i_valid = 1'b0; i_data_a = '0; i_data_b = '0; i_carry = 1'b0;

    tbl.push_back('{"reset0",      1, 1, 32'hDEADBEEF, 32'h12345678, 1, 0, 32'h0,        0});
    tbl.push_back('{"reset1",      1, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 0, 32'h0,        0});
    tbl.push_back('{"idle_after",  0, 0, 32'hAAAA5555, 32'h5555AAAA, 1, 0, 32'h0,        0});
    tbl.push_back('{"basic",       0, 1, 32'h00000005, 32'h00000003, 0, 1, 32'h00000008, 0});
    tbl.push_back('{"chain_cin",   0, 1, 32'hFFFFFFFF, 32'h00000000, 1, 1, 32'h00000000, 1});
    tbl.push_back('{"all_ones",    0, 1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1, 1, 32'hFFFFFFFF, 1});
    tbl.push_back('{"grp_bound",   0, 1, 32'h0000000F, 32'h00000001, 0, 1, 32'h00000010, 0});
    tbl.push_back('{"msb_prop",    0, 1, 32'h7FFFFFFF, 32'h00000001, 0, 1, 32'h80000000, 0});
    tbl.push_back('{"hold",        0, 0, 32'h11111111, 32'h22222222, 1, 0, 32'h80000000, 0});
    tbl.push_back('{"blk_bound",   0, 1, 32'h0000FFFF, 32'h00000001, 0, 1, 32'h00010000, 0});
    tbl.push_back('{"rst_discard", 1, 1, 32'h00000001, 32'h00000001, 0, 0, 32'h0,        0});
    tbl.push_back('{"after_rst",   0, 1, 32'h80000000, 32'h80000000, 0, 1, 32'h00000000, 1});

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].vld, tbl[i].a, tbl[i].b, tbl[i].cin);
      check32(tbl[i].name, tbl[i].exp_v, tbl[i].exp_s, tbl[i].exp_c);
      m_v = tbl[i].exp_v; m_s = tbl[i].exp_s; m_c = tbl[i].exp_c;
    end

    // Back-to-back stream: each result must belong to the operands of the edge just passed.
    for (int i = 0; i < 10; i++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
      step(0, 1, ra, rb, rc);
      model32(0, 1, ra, rb, rc);
      check32("stream", m_v, m_s, m_c);
    end
    step(0, 0, $urandom, $urandom, 1'b1);
    model32(0, 0, '0, '0, 1'b0);
    check32("stream_hold", m_v, m_s, m_c);

    for (int i = 0; i < 1000; i++) begin
      ra = $urandom; rb = $urandom; rc = 1'($urandom_range(0, 1));
      rv = ($urandom_range(0, 3) != 0);
      rr = ($urandom_range(0, 63) == 0);
      step(rr, rv, ra, rb, rc);
      model32(rr, rv, ra, rb, rc);
      check32("random32", m_v, m_s, m_c);
    end

    step_w(1, 1, 8'h12, 8'h34, 1, 1, 16'h1234, 16'h5678, 1);
    check_w("sweep_reset");
    step_w(0, 1, 8'hFF, 8'h01, 0, 1, 16'hFFFF, 16'h0001, 0);
    total++;
    if ({ov8, co8, s8} !== {1'b1, 1'b1, 8'h00}) begin
      bad++;
      $display("FAIL bit8_wrap: got v=%0b c=%0b s=%h, want v=1 c=1 s=00", ov8, co8, s8);
    end
    total++;
    if ({ov16, co16, s16} !== {1'b1, 1'b1, 16'h0000}) begin
      bad++;
      $display("FAIL bit16_wrap: got v=%0b c=%0b s=%h, want v=1 c=1 s=0000", ov16, co16, s16);
    end
    step_w(0, 1, 8'h0F, 8'h01, 0, 1, 16'h0FFF, 16'h0001, 0);
    check_w("sweep_bound");
    for (int i = 0; i < 200; i++) begin
      step_w(0, 1'($urandom_range(0, 1)), 8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
      check_w("sweep_rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cla_adder_reg.md
Name: cla_adder_reg

Overview:
- Parameterised BIT-wide carry-lookahead adder: o_data_s/o_carry = i_data_a + i_data_b + i_carry.
- Built from 4-bit lookahead groups with a second-level group lookahead; result and carry-out are registered.
- Reusable arithmetic leaf for datapath blocks. A behavioural "+" model serves as the golden comparator in verification.

Parameters:
- BIT, 32, operand/sum width. Must be a multiple of 4, minimum 4; other values are unsupported.
- GRP, 4, lookahead group width. Fixed at 4; exposed for documentation only.

Ports:
- i_clk  input  1  rising-edge clock
- i_rst  input  1  synchronous active-high reset
- i_valid  input  1  operands valid this cycle
- i_data_a  input  BIT  addend A, unsigned
- i_data_b  input  BIT  addend B, unsigned
- i_carry  input  1  carry-in
- o_valid  output  1  o_data_s/o_carry valid
- o_data_s  output  BIT  registered sum, low BIT bits
- o_carry  output  1  registered carry-out, bit BIT of the full sum

Behaviour:
- One clock: i_clk. Reset is synchronous and active-high on i_rst.
- Reset: on a rising edge with i_rst=1, o_valid, o_data_s and o_carry all become 0. Reset has priority over i_valid.
- Combinational core, per bit: g=a&b, p=a^b.
- Combinational core, per 4-bit group:
  - c1=g0|p0c0, c2=g1|p1g0|p1p0c0, c3..c4 likewise.
  - Group G=g3|p3g2|p3p2g1|p3p2p1g0; group P=p3p2p1p0.
  - Sum bit s=p^c.
- Group carries are computed by a second-level lookahead over (G,P) pairs in blocks of 4 groups. Block carries chain between blocks, so there is no bit-level ripple anywhere.
- Carry-in of group 0 is i_carry. o_carry is the carry out of the top group.
- Latency is 1 cycle:
  - On a rising edge with i_rst=0 and i_valid=1, the sum and carry of the current inputs are registered and o_valid becomes 1.
  - With i_valid=0, o_valid becomes 0 and o_data_s/o_carry hold their previous values.
- Back-to-back: a new operand set every cycle is allowed. Throughput is one add per cycle; there is no backpressure.
- Wrap-around: the sum is modulo 2^BIT. Overflow is reported only via o_carry; there is no signed overflow flag.
- Reset mid-operation: an input sampled on the same edge as i_rst=1 is discarded.
- Inputs must be stable around the i_clk edge. No X-propagation handling is required beyond plain RTL semantics.

Optional Feature:
- Macro CLA_SELFCHECK_EN.
- When defined:
  - Adds output o_mismatch (1 bit, registered, reset 0).
  - A behavioural reference computes {carry,sum}=a+b+cin in parallel, and its result is registered alongside the main result.
  - o_mismatch=1 in any cycle where o_valid=1 and {o_carry,o_data_s} differs from the reference.
  - A simulation-only $error is also issued on mismatch.
- When undefined: no o_mismatch port and no reference logic. The port list is exactly as above.

Decomposition:
- Package cla_pkg:
  - localparam CLA_GRP=4.
  - Function returning the number of groups for a given BIT, i.e. BIT/4.
  - typedef for the per-group {G,P} pair.
- One sub-module, cla_group4:
  - Inputs: a[3:0], b[3:0], cin.
  - Outputs: s[3:0], G, P.
- The top instantiates BIT/4 groups via generate, adds the second-level lookahead, and holds the output registers.

Test Plan:
- Reset: i_rst=1 for 2 cycles with arbitrary inputs -> o_valid=0, o_data_s=0, o_carry=0; release, with no valid input, outputs stay 0.
- Basic add: a=0x00000005, b=0x00000003, cin=0, i_valid=1 -> next cycle o_valid=1, o_data_s=0x00000008, o_carry=0.
- Full carry chain: a=0xFFFFFFFF, b=0x00000000, cin=1 -> o_data_s=0x00000000, o_carry=1. Also a=0xFFFFFFFF, b=0xFFFFFFFF, cin=1 -> o_data_s=0xFFFFFFFF, o_carry=1.
- Group boundary propagate: a=0x0000000F, b=0x00000001, cin=0 -> o_data_s=0x00000010, o_carry=0. Also a=0x7FFFFFFF, b=0x00000001 -> 0x80000000, o_carry=0.
- Streaming plus hold: 10 random vectors on consecutive cycles -> each result appears exactly 1 cycle later and matches a+b+cin with the carry as bit 32; then i_valid=0 -> o_valid=0 and the last sum is held.
- Self-check (CLA_SELFCHECK_EN) and parameter sweep: 1000 random vectors -> o_mismatch stays 0. Repeat with BIT=8 (a=0xFF, b=0x01, cin=0 -> s=0x00, carry=1) and BIT=16.
